rx78_keyboard: RTL
==================

Name: rx78_keyboard

Overview:
- Keyboard responder for the RX-78 Z80 I/O bus at port 0xF4.
- The CPU writes a strobe value to 0xF4 to select a matrix row, then reads 0xF4 to get that row's column bits.
- The block converts MiSTer `ps2_key` events into a 9x8 key matrix and serves CPU strobe/read cycles from it.
- It replaces the constant-zero 0xF4 read in the top level; the top level ORs `dout` into its I/O read data.

Parameters:
- PORT, 8'hF4, I/O address decoded on addr[7:0].
- ROWS, 9, number of matrix rows (strobe values 1..ROWS).

Ports:
- clk  in  1  system clock (same clock as the CPU).
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggles on each event, [9] pressed, [8] extended, [7:0] scancode.
- clr_all  in  1  synchronous clear of all pressed keys (OSD open, focus loss).
- iorq_n  in  1  Z80 IORQ, active-low.
- wr_n  in  1  Z80 WR, active-low.
- addr  in  8  Z80 A[7:0].
- din  in  8  Z80 data out (write data).
- dout  out  8  read data to CPU; 8'h00 when not addressed.
- any_key  out  1  OR of the whole matrix, registered.

Behaviour:
- Reset (async) clears:
  - dout = 0, any_key = 0;
  - matrix (72 bits) = 0, row_sel = NONE;
  - pipeline valid bits = 0, armed = 0.
- Event capture:
  - First clk after reset: load last_tog <= ps2_key[10] and set armed = 1. No event is generated on this cycle.
  - Thereafter: event = armed & (ps2_key[10] != last_tog); last_tog updates every cycle.
- Pipeline:
  - Stage 1 registers {event, pressed, extended, code}.
  - Stage 2 registers the xlat output {hit, row[3:0], col[2:0], pressed}.
  - Stage 3 writes matrix[row][col] <= pressed when hit.
  - Toggle at cycle t is visible in the matrix at t+3 and in dout at t+4.
  - Back-to-back events one clk apart are all applied in order; no event is dropped.
- Unmapped codes (hit = 0) leave the matrix unchanged.
- Extended codes map only where the table lists them: E0-prefixed cursor keys are mapped; all other extended codes are unmapped.
- clr_all has priority over a same-cycle stage-3 write; the matrix clears.
- CPU write: iorq_n = 0 & wr_n = 0 & addr == PORT. Level-sensitive; the register updates every cycle the condition holds.
  - din 1..ROWS: row_sel = din - 1.
  - din 8'h30: row_sel = ALL.
  - Any other din: row_sel = NONE.
- CPU read: iorq_n = 0 & wr_n = 1 & addr == PORT. Registered with 1-clk latency; dout is re-evaluated every cycle the condition holds.
  - row_sel = row n: dout = matrix[n].
  - row_sel = ALL: dout = OR of all rows.
  - row_sel = NONE: dout = 8'h00.
- When neither condition holds, dout = 8'h00 on the next clk.
- Matrix bits are active-high (1 = pressed).
- A read concurrent with a stage-3 write returns the pre-write value that cycle and the new value on the next cycle.
- any_key = |matrix, updated 1 clk after any matrix change.
- Reset mid-operation: in-flight pipeline events are discarded. Held keys re-register only on their next PS/2 event.

Decomposition:
- Package rx78_kbd_pkg holds:
  - constants PORT_DEFAULT, STROBE_ALL = 8'h30;
  - the row_sel encoding (4-bit: 0..8 rows, 4'hE = ALL, 4'hF = NONE);
  - the typedef kbd_loc_t {hit, row[3:0], col[2:0]};
  - the scancode table.
- Table entries used by the bench:

  Key       Scancode  Row  Col
  '1'       16        0    1
  'A'       1C        2    1
  'Z'       1A        5    2
  Space     29        7    0
  L-Shift   12        8    0
  R-Shift   59        8    1
  E0 Up     E0 75     7    4

- Sub-module rx78_kbd_xlat: combinational scancode + extended -> kbd_loc_t. Its output is registered in the parent as stage 2.

Test Plan:
- Reset release with ps2_key[10] = 1 held -> no matrix change and any_key = 0 after 10 clks. Then write 8'h30 to F4 and read F4 -> dout = 8'h00.
- Toggle ps2_key to {pressed, 0x1C}; write F4 = 3; read F4 -> dout = 8'h02 (row 2, col 1). Read with F4 = 1 -> 8'h00. any_key = 1 exactly 4 clks after the toggle.
- Press 0x12 then 0x59 one clk apart; read row 9 -> 8'h03. Release 0x12 -> 8'h02.
- Press E0 75 and non-extended 0x75; read row 8 -> 8'h10 only. Write F4 = 8'h0A -> read 8'h00.
- Press 0x16 and 0x1A, then assert clr_all in the same cycle as a stage-3 write of 0x29 press -> all rows read 8'h00 and any_key = 0.
- Assert reset mid-pipeline (1 clk after a 0x29 toggle) -> after release, the row 8 read returns 8'h00 and dout = 8'h00 throughout reset.

Source files
------------

// File: rtl/rx78_kbd_pkg.sv
// Shared constants, types and the PS/2 set-2 scancode table for the RX-78 keyboard responder.
package rx78_kbd_pkg;

    localparam logic [7:0]  PORT_DEFAULT = 8'hF4;
    localparam logic [7:0]  STROBE_ALL   = 8'h30;
    localparam int unsigned ROWS_DEFAULT = 9;

    typedef logic [3:0] row_sel_t;
    localparam row_sel_t ROW_ALL  = 4'hE;
    localparam row_sel_t ROW_NONE = 4'hF;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } kbd_loc_t;

    function automatic kbd_loc_t kbd_at(input int unsigned row, input int unsigned col);
        return {1'b1, 4'(row), 3'(col)};
    endfunction

    // Only the E0-prefixed cursor cluster is mapped; every other extended code misses.
    function automatic kbd_loc_t kbd_lookup(input logic ext, input logic [7:0] code);
        kbd_loc_t loc;
        loc = '0;
        if (ext) begin
            case (code)
                8'h6C:   loc = kbd_at(7, 2);
                8'h75:   loc = kbd_at(7, 4);
                8'h72:   loc = kbd_at(7, 5);
                8'h6B:   loc = kbd_at(7, 6);
                8'h74:   loc = kbd_at(7, 7);
                default: loc = '0;
            endcase
        end else begin
            case (code)
                8'h45: loc = kbd_at(0, 0);  8'h16: loc = kbd_at(0, 1);
                8'h1E: loc = kbd_at(0, 2);  8'h26: loc = kbd_at(0, 3);
                8'h25: loc = kbd_at(0, 4);  8'h2E: loc = kbd_at(0, 5);
                8'h36: loc = kbd_at(0, 6);  8'h3D: loc = kbd_at(0, 7);
                8'h3E: loc = kbd_at(1, 0);  8'h46: loc = kbd_at(1, 1);
                8'h52: loc = kbd_at(1, 2);  8'h4C: loc = kbd_at(1, 3);
                8'h41: loc = kbd_at(1, 4);  8'h55: loc = kbd_at(1, 5);
                8'h49: loc = kbd_at(1, 6);  8'h4A: loc = kbd_at(1, 7);
                8'h0E: loc = kbd_at(2, 0);  8'h1C: loc = kbd_at(2, 1);
                8'h32: loc = kbd_at(2, 2);  8'h21: loc = kbd_at(2, 3);
                8'h23: loc = kbd_at(2, 4);  8'h24: loc = kbd_at(2, 5);
                8'h2B: loc = kbd_at(2, 6);  8'h34: loc = kbd_at(2, 7);
                8'h33: loc = kbd_at(3, 0);  8'h43: loc = kbd_at(3, 1);
                8'h3B: loc = kbd_at(3, 2);  8'h42: loc = kbd_at(3, 3);
                8'h4B: loc = kbd_at(3, 4);  8'h3A: loc = kbd_at(3, 5);
                8'h31: loc = kbd_at(3, 6);  8'h44: loc = kbd_at(3, 7);
                8'h4D: loc = kbd_at(4, 0);  8'h15: loc = kbd_at(4, 1);
                8'h2D: loc = kbd_at(4, 2);  8'h1B: loc = kbd_at(4, 3);
                8'h2C: loc = kbd_at(4, 4);  8'h3C: loc = kbd_at(4, 5);
                8'h2A: loc = kbd_at(4, 6);  8'h1D: loc = kbd_at(4, 7);
                8'h22: loc = kbd_at(5, 0);  8'h35: loc = kbd_at(5, 1);
                8'h1A: loc = kbd_at(5, 2);  8'h54: loc = kbd_at(5, 3);
                8'h5D: loc = kbd_at(5, 4);  8'h5B: loc = kbd_at(5, 5);
                8'h61: loc = kbd_at(5, 6);  8'h4E: loc = kbd_at(5, 7);
                8'h05: loc = kbd_at(6, 0);  8'h06: loc = kbd_at(6, 1);
                8'h04: loc = kbd_at(6, 2);  8'h0C: loc = kbd_at(6, 3);
                8'h03: loc = kbd_at(6, 4);  8'h0D: loc = kbd_at(6, 5);
                8'h76: loc = kbd_at(6, 6);
                8'h29: loc = kbd_at(7, 0);  8'h5A: loc = kbd_at(7, 1);
                8'h66: loc = kbd_at(7, 3);
                8'h12: loc = kbd_at(8, 0);  8'h59: loc = kbd_at(8, 1);
                8'h14: loc = kbd_at(8, 2);  8'h11: loc = kbd_at(8, 3);
                default: loc = '0;
            endcase
        end
        return loc;
    endfunction

endpackage

// File: rtl/rx78_keyboard_if.sv
// Z80 I/O bus slice seen by the keyboard responder.
interface rx78_keyboard_if;
    logic       iorq_n;
    logic       wr_n;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output iorq_n, output wr_n, output addr, output din, input dout);
    modport slave  (input iorq_n, input wr_n, input addr, input din, output dout);
endinterface

// File: rtl/rx78_kbd_xlat.sv
// Combinational scancode to matrix-location translation.
module rx78_kbd_xlat
    import rx78_kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output kbd_loc_t   loc
);

    assign loc = kbd_lookup(ext, code);

endmodule

// File: rtl/rx78_keyboard.sv
// RX-78 keyboard responder: PS/2 events into a 9x8 key matrix served on I/O port 0xF4.
module rx78_keyboard
    import rx78_kbd_pkg::*;
#(
    parameter logic [7:0]  PORT = PORT_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [10:0]    ps2_key,
    input  logic           clr_all,
    rx78_keyboard_if.slave bus,
    output logic           any_key
);

    localparam logic [3:0] ROWS_L = 4'(ROWS);
    localparam logic [7:0] ROWS_B = 8'(ROWS);

    logic                  armed_q, last_tog_q;
    logic                  ps2_event;
    logic                  s1_valid_q, s1_pressed_q, s1_ext_q;
    logic [7:0]            s1_code_q;
    kbd_loc_t              loc;
    logic                  s2_hit_q, s2_pressed_q;
    logic [3:0]            s2_row_q;
    logic [2:0]            s2_col_q;
    logic [ROWS-1:0][7:0]  matrix_q;
    row_sel_t              row_sel_q, row_sel_d;
    logic [7:0]            dout_q, dout_d;
    logic [7:0]            din_m1, row_or, rd_data;
    logic                  wr_hit, rd_hit;
    logic                  any_key_q;

    assign ps2_event = armed_q & (ps2_key[10] != last_tog_q);

    rx78_kbd_xlat u_xlat (
        .code (s1_code_q),
        .ext  (s1_ext_q),
        .loc  (loc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q      <= 1'b0;
            last_tog_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_pressed_q <= 1'b0;
            s1_ext_q     <= 1'b0;
            s1_code_q    <= 8'h00;
            s2_hit_q     <= 1'b0;
            s2_pressed_q <= 1'b0;
            s2_row_q     <= 4'h0;
            s2_col_q     <= 3'h0;
        end else begin
            armed_q      <= 1'b1;
            last_tog_q   <= ps2_key[10];
            s1_valid_q   <= ps2_event;
            s1_pressed_q <= ps2_key[9];
            s1_ext_q     <= ps2_key[8];
            s1_code_q    <= ps2_key[7:0];
            s2_hit_q     <= s1_valid_q & loc.hit;
            s2_pressed_q <= s1_pressed_q;
            s2_row_q     <= loc.row;
            s2_col_q     <= loc.col;
        end
    end

    // clr_all wins over a same-cycle stage-3 write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix_q  <= '0;
            any_key_q <= 1'b0;
        end else begin
            if (clr_all) begin
                matrix_q <= '0;
            end else if (s2_hit_q && (s2_row_q < ROWS_L)) begin
                matrix_q[s2_row_q][s2_col_q] <= s2_pressed_q;
            end
            any_key_q <= |matrix_q;
        end
    end

    assign wr_hit = ~bus.iorq_n & ~bus.wr_n & (bus.addr == PORT);
    assign rd_hit = ~bus.iorq_n &  bus.wr_n & (bus.addr == PORT);
    assign din_m1 = bus.din - 8'd1;

    always_comb begin
        row_sel_d = row_sel_q;
        if (wr_hit) begin
            if ((bus.din != 8'h00) && (bus.din <= ROWS_B)) begin
                row_sel_d = din_m1[3:0];
            end else if (bus.din == STROBE_ALL) begin
                row_sel_d = ROW_ALL;
            end else begin
                row_sel_d = ROW_NONE;
            end
        end
    end

    always_comb begin
        row_or = 8'h00;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_or = row_or | matrix_q[r];
        end
        rd_data = 8'h00;
        if (row_sel_q == ROW_ALL) begin
            rd_data = row_or;
        end else if (row_sel_q < ROWS_L) begin
            rd_data = matrix_q[row_sel_q];
        end
        dout_d = rd_hit ? rd_data : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_sel_q <= ROW_NONE;
            dout_q    <= 8'h00;
        end else begin
            row_sel_q <= row_sel_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.dout = dout_q;
    assign any_key  = any_key_q;

endmodule
